// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Control unit for a multicycle MIPS core. One shared ALU, one unified memory
// port, the IR and the register file are sequenced over 3-5 cycles per
// instruction (FETCH / DECODE / EXEC / MEM / WB). The unit drives every
// datapath mux select and write enable. It stalls on the memory ready
// handshake and traps permanently (until reset) on an unknown opcode.
//
// Parameters
//   MEM_HANDSHAKE  1: memory states wait for mem_ready_i
//                  0: mem_ready_i is ignored and treated as always 1
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous active-high reset
//   op_i6         in   opcode field of the IR
//   zero_i        in   ALU zero flag, used by BEQ
//   mem_ready_i   in   memory access completes this cycle
//   mem_req_o     out  memory access request
//   iord_o        out  memory address select: 0 = PC, 1 = ALUOut
//   mem_write_o   out  memory write strobe
//   ir_write_o    out  IR load enable
//   pc_en_o       out  PC load enable = pc_write | (branch & zero_i)
//   pc_src_o2     out  PC source: 00 ALUResult, 01 ALUOut, 10 jump target
//   alu_src_a_o   out  ALU A select: 0 = PC, 1 = rs
//   alu_src_b_o2  out  ALU B select: 00 rt, 01 4, 10 signimm, 11 signimm<<2
//   alu_op_o2     out  ALU op: 00 add, 01 sub, 10 decode funct
//   reg_dst_o     out  write register select: 0 = rt, 1 = rd
//   mem_to_reg_o  out  write data select: 0 = ALUOut, 1 = data register
//   reg_write_o   out  register file write enable
//   instr_done_o  out  one-cycle pulse on the last cycle of an instruction
//   illegal_o     out  sticky trap flag
//   state_o4      out  current state encoding (debug)
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i6,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_en_o,
  output logic [1:0] pc_src_o2,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o2,
  output logic [1:0] alu_op_o2,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o4
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_state_next;

  logic       w_ready;
  logic       w_mem_req;
  logic       w_iord;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic [1:0] w_pc_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_instr_done;
  logic       w_illegal;

  // Without the handshake every memory access completes in its first cycle.
  assign w_ready = MEM_HANDSHAKE ? mem_ready_i : 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 is computed by the ALU in the same cycle the instruction is read,
        // so IR and PC both load exactly when the read completes.
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = w_ready;
        w_pc_write  = w_ready;
        if (w_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC + (signimm<<2) is precomputed into ALUOut here.
        w_alu_src_b = 2'b11;
        case (op_i6)
          OP_RTYPE:     w_state_next = S_EXEC;
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_ADDI:      w_state_next = S_ADDIEX;
          OP_J:         w_state_next = S_JUMP;
          default:      w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_state_next = (op_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (w_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWR: begin
        // The write strobe stays up through wait states; the store is only
        // finished on the cycle memory accepts it.
        w_mem_req    = 1'b1;
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = w_ready;
        if (w_ready) w_state_next = S_FETCH;
      end
      S_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b10;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b01;
        w_pc_src     = 2'b01;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_TRAP: begin
        w_illegal    = 1'b1;
        w_state_next = S_TRAP;
      end
      default: begin
        // Unused encodings 12-14 are treated as a corrupted state.
        w_state_next = S_TRAP;
      end
    endcase
  end

  // Reset forces the state to FETCH asynchronously, but FETCH itself asserts
  // a request and load enables; mask them so nothing fires while rst_i is high.
  assign mem_req_o    = w_mem_req & ~rst_i;
  assign iord_o       = w_iord;
  assign mem_write_o  = w_mem_write & ~rst_i;
  assign ir_write_o   = w_ir_write & ~rst_i;
  assign pc_en_o      = (w_pc_write | (w_branch & zero_i)) & ~rst_i;
  assign pc_src_o2    = w_pc_src;
  assign alu_src_a_o  = w_alu_src_a;
  assign alu_src_b_o2 = w_alu_src_b;
  assign alu_op_o2    = w_alu_op;
  assign reg_dst_o    = w_reg_dst;
  assign mem_to_reg_o = w_mem_to_reg;
  assign reg_write_o  = w_reg_write & ~rst_i;
  assign instr_done_o = w_instr_done & ~rst_i;
  assign illegal_o    = w_illegal & ~rst_i;
  assign state_o4     = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Self-checking bench for mc_ctrl_fsm. Each instruction is expanded into its
// expected per-cycle phase trace (phase, ready level) from the instruction
// class and the chosen wait-state counts; every cycle the full output vector
// is compared against a constant per-phase output table.
// A second instance with MEM_HANDSHAKE=0 and mem_ready_i tied low checks that
// the handshake is ignored.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       rdy;

  logic       mem_req, iord, mem_write, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal;
  logic [3:0] state;

  logic       rst2;
  logic [5:0] op2;
  logic       rdy2 = 1'b0;
  logic       mem_req2, iord2, mem_write2, ir_write2, pc_en2;
  logic [1:0] pc_src2, alu_src_b2, alu_op2;
  logic       alu_src_a2, reg_dst2, mem_to_reg2, reg_write2, instr_done2, illegal2;
  logic [3:0] state2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .op_i6(op), .zero_i(zero), .mem_ready_i(rdy),
    .mem_req_o(mem_req), .iord_o(iord), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .pc_en_o(pc_en), .pc_src_o2(pc_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o2(alu_src_b), .alu_op_o2(alu_op),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .instr_done_o(instr_done), .illegal_o(illegal), .state_o4(state)
  );

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
    .clk_i(clk), .rst_i(rst2), .op_i6(op2), .zero_i(zero), .mem_ready_i(rdy2),
    .mem_req_o(mem_req2), .iord_o(iord2), .mem_write_o(mem_write2),
    .ir_write_o(ir_write2), .pc_en_o(pc_en2), .pc_src_o2(pc_src2),
    .alu_src_a_o(alu_src_a2), .alu_src_b_o2(alu_src_b2), .alu_op_o2(alu_op2),
    .reg_dst_o(reg_dst2), .mem_to_reg_o(mem_to_reg2), .reg_write_o(reg_write2),
    .instr_done_o(instr_done2), .illegal_o(illegal2), .state_o4(state2)
  );

  // Packed view: {mem_req, iord, mem_write, ir_write, pc_en, pc_src[1:0],
  // srcA, srcB[1:0], aluop[1:0], reg_dst, mem_to_reg, reg_write, done,
  // illegal, state[3:0]}
  logic [20:0] obs, obs2;
  assign obs  = {mem_req, iord, mem_write, ir_write, pc_en, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done,
                 illegal, state};
  assign obs2 = {mem_req2, iord2, mem_write2, ir_write2, pc_en2, pc_src2, alu_src_a2,
                 alu_src_b2, alu_op2, reg_dst2, mem_to_reg2, reg_write2, instr_done2,
                 illegal2, state2};

  // Expected outputs for one cycle spent in phase ph with ready r and zero z.
  function automatic logic [20:0] exp_vec(int ph, bit r, bit z);
    logic mreq, io, mw, irw, pce, sa, rd, m2r, rw, dn, ill;
    logic [1:0] pcs, sb, ao;
    {mreq, io, mw, irw, pce, sa, rd, m2r, rw, dn, ill} = '0;
    pcs = 2'b00; sb = 2'b00; ao = 2'b00;
    case (ph)
      0:  begin mreq = 1; sb = 2'b01; irw = r; pce = r; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mreq = 1; io = 1; end
      4:  begin m2r = 1; rw = 1; dn = 1; end
      5:  begin mreq = 1; io = 1; mw = 1; dn = r; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; dn = 1; end
      8:  begin sa = 1; ao = 2'b01; pcs = 2'b01; pce = z; dn = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; dn = 1; end
      11: begin pcs = 2'b10; pce = 1; dn = 1; end
      15: ill = 1;
      default: ;
    endcase
    return {mreq, io, mw, irw, pce, pcs, sa, sb, ao, rd, m2r, rw, dn, ill, 4'(ph)};
  endfunction

  // While in reset: FETCH mux values, every enable low, state 0.
  function automatic logic [20:0] rst_vec();
    logic [20:0] v;
    v = exp_vec(0, 1'b0, 1'b0);
    v[20] = 1'b0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s observed=%06h expected=%06h", tag, o, e);
    end
  endtask

  // One clock cycle in phase ph with ready level r.
  task automatic step(input int ph, input bit r);
    rdy = r;
    @(negedge clk);
    check($sformatf("phase%0d_rdy%0d_z%0d", ph, r, zero), obs, exp_vec(ph, r, zero));
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its phase trace: fw fetch waits, mw memory waits.
  task automatic run_instr(input logic [5:0] o, input bit z, input int fw, input int mw);
    int cyc;
    op = o; zero = z;
    cyc = fw + 1;
    for (int i = 0; i < fw; i++) step(0, 1'b0);
    step(0, 1'b1);
    step(1, rb()); cyc++;
    case (o)
      6'b000000: begin step(6, rb()); step(7, rb()); cyc += 2; end
      6'b100011: begin
        step(2, rb());
        for (int i = 0; i < mw; i++) step(3, 1'b0);
        step(3, 1'b1); step(4, rb()); cyc += 3 + mw;
      end
      6'b101011: begin
        step(2, rb());
        for (int i = 0; i < mw; i++) step(5, 1'b0);
        step(5, 1'b1); cyc += 2 + mw;
      end
      6'b000100: begin step(8, rb()); cyc += 1; end
      6'b001000: begin step(9, rb()); step(10, rb()); cyc += 2; end
      6'b000010: begin step(11, rb()); cyc += 1; end
      default:   begin step(15, rb()); cyc += 1; end
    endcase
    $display("instr op=%b zero=%0d fetch_waits=%0d mem_waits=%0d cycles=%0d",
             o, z, fw, mw, cyc);
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    rst = 1'b1; rst2 = 1'b1; op = '0; op2 = '0; zero = 1'b0; rdy = 1'b1;

    // Reset state, with ready high to show FETCH enables are masked.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", obs, rst_vec());
    check("reset_nohs", obs2, rst_vec());
    @(posedge clk); #1;
    rst = 1'b0;

    // LW with no waits: 0,1,2,3,4 then FETCH.
    run_instr(6'b100011, 1'b0, 0, 0);
    // SW held two cycles in MEMWR.
    run_instr(6'b101011, 1'b0, 0, 2);
    // BEQ taken, then not taken.
    run_instr(6'b000100, 1'b1, 0, 0);
    run_instr(6'b000100, 1'b0, 0, 0);
    run_instr(6'b000000, 1'b0, 1, 0);
    run_instr(6'b001000, 1'b0, 0, 0);
    run_instr(6'b000010, 1'b0, 2, 0);

    // Randomised instruction mix with random wait states.
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], rb(),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Illegal opcode traps and stays trapped until reset.
    run_instr(6'b111111, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      op = 6'($urandom); zero = rb();
      step(15, rb());
    end
    rst = 1'b1;
    @(negedge clk);
    check("trap_reset", obs, rst_vec());
    @(posedge clk); #1;
    rst = 1'b0; zero = 1'b0;
    run_instr(6'b000000, 1'b0, 0, 0);

    // Asynchronous reset mid-load while stalled in MEMRD.
    op = 6'b100011;
    step(0, 1'b1); step(1, 1'b0); step(2, 1'b0);
    rdy = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst_memrd", obs, rst_vec());
    rdy = 1'b1;
    @(posedge clk); #1;
    check("async_rst_hold", obs, rst_vec());
    rst = 1'b0;
    run_instr(6'b100011, 1'b0, 0, 1);
    $display("instr async reset in MEMRD then refetch");

    // Handshake disabled, ready tied low: R-type still completes in 4 cycles.
    op2 = 6'b000000; zero = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0;
    begin
      int ph_seq [5];
      ph_seq = '{0, 1, 6, 7, 0};
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("nohs_cycle%0d", k), obs2, exp_vec(ph_seq[k], 1'b1, zero));
        @(posedge clk); #1;
      end
    end
    $display("instr no-handshake R-type cycles=4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
